// File: rtl/sensor_conditioner.sv
// -----------------------------------------------------------------------------
// sensor_conditioner
//
// Input conditioning for the watering controller. The raw light (SL) and
// soil-humidity (SH) pins are synchronised to Clk, debounced, and every
// accepted change is followed by a hold window during which the channel
// ignores its input. The outputs drive the controller's SL/SH inputs directly.
//
// Ports:
//   Clk     in   system clock (50 MHz)
//   reset   in   asynchronous reset, active low
//   SL_raw  in   raw light-sensor pin, asynchronous to Clk
//   SH_raw  in   raw humidity-sensor pin, asynchronous to Clk
//   SL      out  conditioned light level
//   SH      out  conditioned humidity level
//   SL_chg  out  one-cycle strobe when SL changes after acquisition
//   SH_chg  out  one-cycle strobe when SH changes after acquisition
//   ready   out  high once both channels have acquired an initial level
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive samples a new level must persist (>= 2)
//   HOLD_CYCLES      cycles the input is ignored after a change (>= 1)
//   CNT_W            counter width, 2^CNT_W > max(DEBOUNCE_CYCLES, HOLD_CYCLES)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// sensor_channel
//
// One conditioned channel: 2-flop synchroniser followed by an
// ACQ / STABLE / DEBOUNCE / HOLD state machine sharing a single counter.
//
// Ports:
//   Clk         in   system clock
//   reset       in   asynchronous reset, active low
//   i_raw       in   raw pin level
//   o_level     out  conditioned level (registered)
//   o_chg       out  one-cycle strobe on an accepted change (registered)
//   o_acquired  out  high once an initial level has been acquired
// -----------------------------------------------------------------------------
module sensor_channel #(
    parameter int DEBOUNCE_CYCLES = 2_500_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int CNT_W           = 26
) (
    input  logic Clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_chg,
    output logic o_acquired
);

    typedef enum logic [1:0] {
        ST_ACQ,
        ST_STABLE,
        ST_DEBOUNCE,
        ST_HOLD
    } state_t;

    // Terminal counts are compared against the value held *before* the edge,
    // so the edge that takes the N-th sample sees N-1 in the counter.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_last;     // previous synchronised sample, used only in ACQ
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    logic             r_level;
    logic             r_chg;
    logic             r_acquired;

    logic             w_s;

    assign w_s = r_sync2;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_last     <= 1'b0;
            r_cnt      <= '0;
            r_state    <= ST_ACQ;
            r_level    <= 1'b0;
            r_chg      <= 1'b0;
            r_acquired <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_chg   <= 1'b0;

            case (r_state)
                // Wait for the synchronised input to sit still long enough,
                // then adopt it silently (no strobe, no hold).
                ST_ACQ: begin
                    r_last <= w_s;
                    if (w_s != r_last) begin
                        r_cnt <= CNT_ONE;
                    end else if (r_cnt == DEB_LAST) begin
                        r_level    <= w_s;
                        r_acquired <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= ST_STABLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                // The first differing sample already counts as sample one.
                ST_STABLE: begin
                    r_cnt <= '0;
                    if (w_s != r_level) begin
                        r_cnt   <= CNT_ONE;
                        r_state <= ST_DEBOUNCE;
                    end
                end

                ST_DEBOUNCE: begin
                    if (w_s == r_level) begin
                        // Glitch: input returned before it was accepted.
                        r_cnt   <= '0;
                        r_state <= ST_STABLE;
                    end else if (r_cnt == DEB_LAST) begin
                        r_level <= ~r_level;
                        r_chg   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                // Input is ignored; samples seen here never count towards
                // the next debounce.
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_STABLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_ACQ;
                end
            endcase
        end
    end

    assign o_level    = r_level;
    assign o_chg      = r_chg;
    assign o_acquired = r_acquired;

endmodule

module sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 2_500_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int CNT_W           = 26
) (
    input  logic Clk,
    input  logic reset,
    input  logic SL_raw,
    input  logic SH_raw,
    output logic SL,
    output logic SH,
    output logic SL_chg,
    output logic SH_chg,
    output logic ready
);

    // Channel 0 = light (SL), channel 1 = humidity (SH).
    logic [1:0] w_raw;
    logic [1:0] w_level;
    logic [1:0] w_chg;
    logic [1:0] w_acquired;
    logic       r_ready;

    assign w_raw = {SH_raw, SL_raw};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            sensor_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .HOLD_CYCLES     (HOLD_CYCLES),
                .CNT_W           (CNT_W)
            ) u_chan (
                .Clk        (Clk),
                .reset      (reset),
                .i_raw      (w_raw[gi]),
                .o_level    (w_level[gi]),
                .o_chg      (w_chg[gi]),
                .o_acquired (w_acquired[gi])
            );
        end
    endgenerate

    // Sticky: rises the edge after both channels have acquired, cleared
    // only by reset.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_ready <= 1'b0;
        end else if (&w_acquired) begin
            r_ready <= 1'b1;
        end
    end

    assign SL     = w_level[0];
    assign SH     = w_level[1];
    assign SL_chg = w_chg[0];
    assign SH_chg = w_chg[1];
    assign ready  = r_ready;

endmodule

// File: tb/tb_sensor_conditioner.sv
module tb_sensor_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic Clk    = 1'b0;
    logic reset  = 1'b0;
    logic SL_raw = 1'b1;
    logic SH_raw = 1'b0;
    logic SL;
    logic SH;
    logic SL_chg;
    logic SH_chg;
    logic ready;

    int checks    = 0;
    int errors    = 0;
    int edge_n    = 0;
    int sl_pulses = 0;
    int sh_pulses = 0;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .CNT_W           (26)
    ) dut (
        .Clk    (Clk),
        .reset  (reset),
        .SL_raw (SL_raw),
        .SH_raw (SH_raw),
        .SL     (SL),
        .SH     (SH),
        .SL_chg (SL_chg),
        .SH_chg (SH_chg),
        .ready  (ready)
    );

    always #5 Clk = ~Clk;

    initial forever begin
        @(posedge Clk);
        edge_n++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_until(input int e);
        while (edge_n < e) @(negedge Clk);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Index 0 = SL, 1 = SH. Time is tracked in absolute
    // edges since reset release; a hold is an interval of ignored edges.
    // ------------------------------------------------------------------
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_prev [2];
    bit m_acq [2];
    bit m_out [2];
    bit m_chg [2];
    int m_run [2];
    int m_hold_end [2];
    bit m_ready;
    int m_edge;

    initial forever begin
        @(posedge Clk or negedge reset);
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_prev[c] = 0; m_acq[c] = 0;
                m_out[c] = 0; m_chg[c] = 0; m_run[c] = 0; m_hold_end[c] = 0;
            end
            m_ready = 0;
            m_edge  = 0;
        end else begin
            bit raw [2];
            bit s;
            raw[0] = SL_raw;
            raw[1] = SH_raw;
            m_edge++;
            m_ready = m_ready | (m_acq[0] & m_acq[1]);
            for (int c = 0; c < 2; c++) begin
                // s = raw value as it was two edges ago (zero right after reset)
                s = m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = raw[c];
                m_chg[c] = 0;
                if (!m_acq[c]) begin
                    if (s == m_prev[c]) m_run[c]++;
                    else m_run[c] = 1;
                    m_prev[c] = s;
                    if (m_run[c] == DEB) begin
                        m_acq[c] = 1;
                        m_out[c] = s;
                        m_run[c] = 0;
                    end
                end else if (m_edge <= m_hold_end[c]) begin
                    m_run[c] = 0;
                end else begin
                    if (s != m_out[c]) m_run[c]++;
                    else m_run[c] = 0;
                    if (m_run[c] == DEB) begin
                        m_out[c]      = !m_out[c];
                        m_chg[c]      = 1;
                        m_run[c]      = 0;
                        m_hold_end[c] = m_edge + HOLD;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(posedge Clk);
        #1;
        check("cyc_SL",     SL,     m_out[0]);
        check("cyc_SH",     SH,     m_out[1]);
        check("cyc_SL_chg", SL_chg, m_chg[0]);
        check("cyc_SH_chg", SH_chg, m_chg[1]);
        check("cyc_ready",  ready,  m_ready);
        if (SL_chg === 1'b1) sl_pulses++;
        if (SH_chg === 1'b1) sh_pulses++;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    initial begin : stim
        int r;
        int k;
        int a;
        int p0;

        // Reset / acquire
        repeat (3) begin
            @(negedge Clk);
            check("rst_SL", SL, 0);
            check("rst_SH", SH, 0);
            check("rst_ready", ready, 0);
        end
        reset = 1'b1;
        r = edge_n;
        wait_until(r + 6);
        check("acq_SL", SL, 1);
        check("acq_SH", SH, 0);
        check("acq_ready_early", ready, 0);
        wait_until(r + 7);
        check("acq_ready", ready, 1);
        check("acq_no_pulse", sl_pulses + sh_pulses, 0);
        $display("reset/acquire: SL=%0d SH=%0d ready=%0d at edge %0d", SL, SH, ready, edge_n);

        // Clean change on SH
        wait_until(r + 10);
        SH_raw = 1'b1;
        k = edge_n + 1;
        wait_until(k + 4);
        check("clean_SH_pre", SH, 0);
        wait_until(k + 5);
        check("clean_SH", SH, 1);
        check("clean_SH_chg", SH_chg, 1);
        check("clean_SL", SL, 1);
        wait_until(k + 6);
        check("clean_SH_chg_end", SH_chg, 0);
        $display("clean change: SH=%0d at edge %0d", SH, edge_n);
        wait_until(k + 16);

        // Glitch rejection: 3-cycle low pulse on SL
        p0 = sl_pulses;
        SL_raw = 1'b0;
        k = edge_n + 1;
        wait_until(k + 2);
        SL_raw = 1'b1;
        wait_until(k + 8);
        check("glitch_SL", SL, 1);
        check("glitch_no_pulse", sl_pulses - p0, 0);
        $display("glitch: SL=%0d pulses=%0d at edge %0d", SL, sl_pulses - p0, edge_n);

        // 4-cycle low pulse is accepted, then reverts after the hold
        SL_raw = 1'b0;
        k = edge_n + 1;
        wait_until(k + 3);
        SL_raw = 1'b1;
        wait_until(k + 4);
        check("pulse4_SL_pre", SL, 1);
        wait_until(k + 5);
        check("pulse4_SL", SL, 0);
        check("pulse4_SL_chg", SL_chg, 1);
        wait_until(k + 16);
        check("pulse4_SL_held", SL, 0);
        wait_until(k + 17);
        check("pulse4_SL_back", SL, 1);
        check("pulse4_SL_chg_back", SL_chg, 1);
        $display("4-cycle pulse: SL back to %0d at edge %0d", SL, edge_n);
        wait_until(k + 30);

        // Hold: SH toggles, raw toggles back 2 cycles after the change
        p0 = sh_pulses;
        SH_raw = 1'b0;
        k = edge_n + 1;
        a = k + 5;
        wait_until(a);
        check("hold_SH", SH, 0);
        check("hold_SH_chg", SH_chg, 1);
        wait_until(a + 2);
        SH_raw = 1'b1;
        wait_until(a + 8);
        check("hold_SH_held", SH, 0);
        wait_until(a + 11);
        check("hold_SH_pre", SH, 0);
        wait_until(a + 12);
        check("hold_SH_revert", SH, 1);
        check("hold_SH_chg2", SH_chg, 1);
        wait_until(a + 24);
        check("hold_pulse_count", sh_pulses - p0, 2);
        $display("hold: SH=%0d pulses=%0d at edge %0d", SH, sh_pulses - p0, edge_n);

        // Simultaneous change on both channels
        SL_raw = 1'b0;
        SH_raw = 1'b0;
        k = edge_n + 1;
        wait_until(k + 5);
        check("simul_SL", SL, 0);
        check("simul_SH", SH, 0);
        check("simul_SL_chg", SL_chg, 1);
        check("simul_SH_chg", SH_chg, 1);
        $display("simultaneous: SL=%0d SH=%0d at edge %0d", SL, SH, edge_n);
        wait_until(k + 16);

        // Reset in the middle of a debounce
        SL_raw = 1'b1;
        k = edge_n + 1;
        wait_until(k + 3);
        check("dbrst_pre_ready", ready, 1);
        #2 reset = 1'b0;
        #1;
        check("dbrst_ready", ready, 0);
        check("dbrst_SL", SL, 0);
        check("dbrst_SL_chg", SL_chg, 0);
        repeat (2) @(negedge Clk);
        reset = 1'b1;
        r = edge_n;
        wait_until(r + 6);
        check("reacq1_SL", SL, 1);
        check("reacq1_SH", SH, 0);
        wait_until(r + 7);
        check("reacq1_ready", ready, 1);
        $display("reset during debounce: reacquired ready=%0d at edge %0d", ready, edge_n);

        // Reset in the middle of a hold
        wait_until(r + 10);
        SH_raw = 1'b1;
        k = edge_n + 1;
        wait_until(k + 5);
        check("hdrst_SH", SH, 1);
        check("hdrst_SH_chg", SH_chg, 1);
        wait_until(k + 7);
        check("hdrst_pre_SL", SL, 1);
        #2 reset = 1'b0;
        #1;
        check("hdrst_SL", SL, 0);
        check("hdrst_SH", SH, 0);
        check("hdrst_ready", ready, 0);
        repeat (2) @(negedge Clk);
        reset = 1'b1;
        r = edge_n;
        wait_until(r + 6);
        check("reacq2_SL", SL, 1);
        check("reacq2_SH", SH, 1);
        check("reacq2_ready_early", ready, 0);
        wait_until(r + 7);
        check("reacq2_ready", ready, 1);
        $display("reset during hold: reacquired SL=%0d SH=%0d at edge %0d", SL, SH, edge_n);
        wait_until(r + 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
